ofs_plat_local_mem_bank_arbiter: RTL and testbench
==================================================

Name: ofs_plat_local_mem_bank_arbiter

Overview:
- Shares one local-memory bank between NUM_REQ Avalon-MM requesters.
- The bank is one element of the banks[] array of the local-memory FIU interface.
- Arbitrates command beats round-robin and holds the grant for the full length of a write burst.
- Tracks outstanding read bursts in order and routes each readdata beat back to the requester that issued the read.
- Sits between AFU-side memory clients and the FIU bank port.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 27, word address width.
- DATA_WIDTH, 512, data bus width (ECC included when applicable).
- BURST_CNT_WIDTH, 7, burstcount width (max burst 2^(BURST_CNT_WIDTH-1)).
- RSP_DEPTH, 64, maximum outstanding read bursts (power of 2).

Ports:
- clk  in  1  bank clock.
- reset_n  in  1  async active-low reset.
- req_read  in  NUM_REQ  per-requester read request.
- req_write  in  NUM_REQ  per-requester write beat.
- req_address  in  NUM_REQ*ADDR_WIDTH  packed addresses.
- req_burstcount  in  NUM_REQ*BURST_CNT_WIDTH  packed burst counts.
- req_writedata  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_byteenable  in  NUM_REQ*DATA_WIDTH/8  packed byte enables.
- req_waitrequest  out  NUM_REQ  per-requester stall.
- req_readdata  out  DATA_WIDTH  broadcast read data.
- req_readdatavalid  out  NUM_REQ  one-hot read data valid.
- m_read  out  1  to bank.
- m_write  out  1  to bank.
- m_address  out  ADDR_WIDTH  to bank.
- m_burstcount  out  BURST_CNT_WIDTH  to bank.
- m_writedata  out  DATA_WIDTH  to bank.
- m_byteenable  out  DATA_WIDTH/8  to bank.
- m_waitrequest  in  1  bank stall (WAIT_REQUEST_ALLOWANCE=0 semantics).
- m_readdata  in  DATA_WIDTH  from bank.
- m_readdatavalid  in  1  from bank.

Behaviour:
- Reset (async on reset_n low, released synchronously to clk):
  - rr pointer = 0; burst lock clear; write beat counter = 0; tracker empty.
  - m_read = m_write = 0; req_readdatavalid = 0; req_waitrequest = all 1 while reset is asserted.
- Reset mid-operation: the in-flight burst and all outstanding reads are discarded without recovery.
- Requests: requester i is requesting when req_read[i] | req_write[i]. Asserting both in one cycle is illegal (assertion).
- Unlocked arbitration (combinational, same cycle):
  - grant = first requesting index at or after the rr pointer, wrapping modulo NUM_REQ.
  - The rr pointer advances to grant+1 only when a command beat is accepted.
- Command path is a zero-latency mux: m_* = req_*[grant].
  - m_read is additionally gated by !trk_full; m_write is not gated.
  - Beat accepted when (m_read | m_write) & !m_waitrequest.
- req_waitrequest[i] = !(grant==i & !m_waitrequest & (req_write[i] | !trk_full)). All non-granted requesters see 1.
- Write burst lock:
  - On acceptance of a write beat with burstcount B>1 while unlocked: set lock, hold grant, load beat counter = B-1.
  - Each further accepted beat decrements the counter; lock clears on the beat that takes the counter to 0.
  - While locked only the owner is granted, and its burstcount and address are ignored.
  - B=1 takes no lock. burstcount=0 is illegal (assertion).
- Read: a single command beat.
  - On acceptance, push {id=grant, len=burstcount} into the tracker.
  - A read is never granted while locked.
- Response routing:
  - When m_readdatavalid is high, req_readdatavalid = onehot(head.id) and req_readdata = m_readdata, same cycle (combinational).
  - Head remaining count starts at len and decrements per beat; pop on the last beat.
  - m_readdatavalid while the tracker is empty is an error: assertion, beat dropped.
- Tracker limits:
  - trk_full when RSP_DEPTH entries are outstanding.
  - Push and pop in the same cycle are both allowed when full; full does not change.
- Pointer wrap: wrap of tracker pointers and of the rr pointer is modulo.
- No reordering: bank responses are in order, so routing is strictly FIFO.

Decomposition:
- Package ofs_plat_local_mem_arb_pkg holds:
  - typedef t_rsp_entry {id: $clog2(NUM_REQ) bits, len: BURST_CNT_WIDTH bits};
  - function rr_pick(req, ptr).
- One sub-module, ofs_plat_local_mem_rsp_tracker: RSP_DEPTH-entry FIFO plus head beat counter.
  - Outputs: head_id, last_beat, full, empty.

Test Plan:
- Single requester 0 issues read addr 0x10 burst 4; bank returns 4 beats -> req_readdatavalid = 0b01 for 4 cycles; tracker empty afterwards.
- Req0 and req1 both issue reads continuously with no bank stall -> grants alternate 0,1,0,1; each receives its own data in issue order.
- Req0 write burst 8 while req1 requests a read from beat 2 onward -> req1 waitrequest = 1 until req0's 8th beat is accepted; req1 is granted the next cycle.
- Hold m_waitrequest = 1 for 5 cycles mid write burst -> m_* stable, counter unchanged, burst completes with exactly 8 beats.
- Issue 64 reads with no responses -> 65th read sees waitrequest = 1 while a write from the other requester is still accepted; first response beat frees a slot.
- Assert reset_n low mid read burst (2 of 4 beats returned) -> outputs reach reset values asynchronously; after release, a fresh read routes correctly.

Source files
------------

// File: rtl/ofs_plat_local_mem_arb_pkg.sv
// Shared types and helpers for the local-memory bank arbiter.
// Entry fields are sized for the largest supported configuration (8 requesters).
package ofs_plat_local_mem_arb_pkg;

    localparam int unsigned MAX_NUM_REQ = 8;
    localparam int unsigned REQ_ID_W    = 3;
    localparam int unsigned RSP_LEN_W   = 16;

    typedef struct packed {
        logic [REQ_ID_W-1:0]  id;
        logic [RSP_LEN_W-1:0] len;
    } t_rsp_entry;

    typedef enum logic {
        ARB_OPEN,
        ARB_LOCKED
    } t_arb_state;

    // First requesting index at or after ptr, wrapping modulo num_req.
    // Scanning from the far end lets the nearest hit overwrite the earlier ones.
    function automatic logic [REQ_ID_W-1:0] rr_pick(
        input logic [MAX_NUM_REQ-1:0] req,
        input logic [REQ_ID_W-1:0]    ptr,
        input int unsigned            num_req
    );
        logic [REQ_ID_W-1:0] pick;
        logic [REQ_ID_W-1:0] sel;
        int unsigned         idx;
        pick = ptr;
        for (int unsigned k = 0; k < MAX_NUM_REQ; k++) begin
            if (k < num_req) begin
                idx = (32'(ptr) + num_req - 1 - k) % num_req;
                sel = REQ_ID_W'(idx);
                if (req[sel]) pick = sel;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/ofs_plat_local_mem_rsp_tracker.sv
// In-order record of outstanding read bursts; the head entry names the
// requester that owns the next returning beat.
module ofs_plat_local_mem_rsp_tracker
    import ofs_plat_local_mem_arb_pkg::*;
#(
    parameter int unsigned RSP_DEPTH = 64
)(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                push,
    input  t_rsp_entry          push_entry,
    input  logic                beat,
    output logic [REQ_ID_W-1:0] head_id,
    output logic                last_beat,
    output logic                full,
    output logic                empty
);

    localparam int unsigned PTR_W = $clog2(RSP_DEPTH);

    t_rsp_entry           mem [RSP_DEPTH];
    t_rsp_entry           head;
    logic [PTR_W:0]       wr_ptr;
    logic [PTR_W:0]       rd_ptr;
    logic [RSP_LEN_W-1:0] beats_done;
    logic                 pop;
    logic                 do_push;

    assign head      = mem[rd_ptr[PTR_W-1:0]];
    assign head_id   = head.id;
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign last_beat = !empty && (beats_done == head.len - 1'b1);
    assign pop       = beat && last_beat;
    // A push into a full tracker is safe when the head is retiring this cycle.
    assign do_push   = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_entry;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            beats_done <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                beats_done <= '0;
            end else if (beat && !empty) begin
                beats_done <= beats_done + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ofs_plat_local_mem_bank_arbiter.sv
// Round-robin sharing of one local-memory bank among NUM_REQ Avalon-MM
// requesters, with write-burst locking and in-order read response routing.
module ofs_plat_local_mem_bank_arbiter
    import ofs_plat_local_mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned ADDR_WIDTH      = 27,
    parameter int unsigned DATA_WIDTH      = 512,
    parameter int unsigned BURST_CNT_WIDTH = 7,
    parameter int unsigned RSP_DEPTH       = 64
)(
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [NUM_REQ-1:0]                   req_read,
    input  logic [NUM_REQ-1:0]                   req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]        req_address,
    input  logic [NUM_REQ*BURST_CNT_WIDTH-1:0]   req_burstcount,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]        req_writedata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]      req_byteenable,
    output logic [NUM_REQ-1:0]                   req_waitrequest,
    output logic [DATA_WIDTH-1:0]                req_readdata,
    output logic [NUM_REQ-1:0]                   req_readdatavalid,
    output logic                                 m_read,
    output logic                                 m_write,
    output logic [ADDR_WIDTH-1:0]                m_address,
    output logic [BURST_CNT_WIDTH-1:0]           m_burstcount,
    output logic [DATA_WIDTH-1:0]                m_writedata,
    output logic [DATA_WIDTH/8-1:0]              m_byteenable,
    input  logic                                 m_waitrequest,
    input  logic [DATA_WIDTH-1:0]                m_readdata,
    input  logic                                 m_readdatavalid
);

    localparam int unsigned GW   = $clog2(NUM_REQ);
    localparam int unsigned BE_W = DATA_WIDTH / 8;

    t_arb_state                 state, state_next;
    logic [GW-1:0]              rr_ptr;
    logic [GW-1:0]              owner;
    logic [GW-1:0]              grant;
    logic [BURST_CNT_WIDTH-1:0] beat_cnt;
    logic [BURST_CNT_WIDTH-1:0] lock_bcnt;
    logic [ADDR_WIDTH-1:0]      lock_addr;
    logic [NUM_REQ-1:0]         req_any;
    logic                       grant_read;
    logic                       grant_write;
    logic                       accept;
    logic                       trk_full;
    logic                       trk_empty;
    logic                       trk_last;
    logic [REQ_ID_W-1:0]        head_id;
    t_rsp_entry                 push_entry;

    assign req_any = req_read | req_write;
    assign grant   = (state == ARB_LOCKED) ? owner :
                     GW'(rr_pick(MAX_NUM_REQ'(req_any), REQ_ID_W'(rr_ptr), NUM_REQ));

    always_comb begin
        state_next      = state;
        m_address       = req_address[grant*ADDR_WIDTH +: ADDR_WIDTH];
        m_burstcount    = req_burstcount[grant*BURST_CNT_WIDTH +: BURST_CNT_WIDTH];
        m_writedata     = req_writedata[grant*DATA_WIDTH +: DATA_WIDTH];
        m_byteenable    = req_byteenable[grant*BE_W +: BE_W];
        grant_read      = req_read[grant] && (state == ARB_OPEN);
        grant_write     = req_write[grant];
        // Address and length of a locked burst come from its first beat.
        if (state == ARB_LOCKED) begin
            m_address    = lock_addr;
            m_burstcount = lock_bcnt;
        end
        m_read          = reset_n && grant_read && !trk_full;
        m_write         = reset_n && grant_write;
        accept          = (m_read || m_write) && !m_waitrequest;
        req_waitrequest = '1;
        if (reset_n && !m_waitrequest && (grant_write || (grant_read && !trk_full)))
            req_waitrequest[grant] = 1'b0;
        case (state)
            ARB_OPEN:
                if (accept && m_write && (m_burstcount > BURST_CNT_WIDTH'(1)))
                    state_next = ARB_LOCKED;
            ARB_LOCKED:
                if (accept && (beat_cnt == BURST_CNT_WIDTH'(1)))
                    state_next = ARB_OPEN;
            default:
                state_next = ARB_OPEN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ARB_OPEN;
            rr_ptr    <= '0;
            owner     <= '0;
            beat_cnt  <= '0;
            lock_addr <= '0;
            lock_bcnt <= '0;
        end else begin
            state <= state_next;
            if (accept)
                rr_ptr <= (grant == GW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            if (state == ARB_OPEN && state_next == ARB_LOCKED) begin
                owner     <= grant;
                beat_cnt  <= m_burstcount - 1'b1;
                lock_addr <= m_address;
                lock_bcnt <= m_burstcount;
            end else if (state == ARB_LOCKED && accept) begin
                beat_cnt  <= beat_cnt - 1'b1;
            end
        end
    end

    assign push_entry = '{id: REQ_ID_W'(grant), len: RSP_LEN_W'(m_burstcount)};

    ofs_plat_local_mem_rsp_tracker #(
        .RSP_DEPTH (RSP_DEPTH)
    ) u_rsp_tracker (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (accept && m_read),
        .push_entry (push_entry),
        .beat       (m_readdatavalid),
        .head_id    (head_id),
        .last_beat  (trk_last),
        .full       (trk_full),
        .empty      (trk_empty)
    );

    assign req_readdata      = m_readdata;
    assign req_readdatavalid = (reset_n && m_readdatavalid && !trk_empty) ?
                               (NUM_REQ'(1'b1) << head_id) : '0;

    a_rd_wr_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
        (req_read & req_write) == '0);
    a_burstcount_nonzero: assert property (@(posedge clk) disable iff (!reset_n)
        (accept && state == ARB_OPEN) |-> (m_burstcount != '0));
    a_rsp_expected: assert property (@(posedge clk) disable iff (!reset_n)
        m_readdatavalid |-> !trk_empty);
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset_n)
        (trk_full && !(m_readdatavalid && trk_last)) |-> !(accept && m_read));

endmodule

// File: tb/tb_ofs_plat_local_mem_bank_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// queue-based model of arbitration, burst locking and read routing.
module tb_ofs_plat_local_mem_bank_arbiter;

    localparam int N     = 2;
    localparam int AW    = 27;
    localparam int DW    = 64;
    localparam int BW    = 7;
    localparam int BEW   = DW / 8;
    localparam int DEPTH = 64;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic [N-1:0]      req_read, req_write;
    logic [N*AW-1:0]   req_address;
    logic [N*BW-1:0]   req_burstcount;
    logic [N*DW-1:0]   req_writedata;
    logic [N*BEW-1:0]  req_byteenable;
    logic [N-1:0]      req_waitrequest;
    logic [DW-1:0]     req_readdata;
    logic [N-1:0]      req_readdatavalid;
    logic              m_read, m_write;
    logic [AW-1:0]     m_address;
    logic [BW-1:0]     m_burstcount;
    logic [DW-1:0]     m_writedata;
    logic [BEW-1:0]    m_byteenable;
    logic              m_waitrequest;
    logic [DW-1:0]     m_readdata;
    logic              m_readdatavalid;

    ofs_plat_local_mem_bank_arbiter #(
        .NUM_REQ         (N),
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .BURST_CNT_WIDTH (BW),
        .RSP_DEPTH       (DEPTH)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req_read          (req_read),
        .req_write         (req_write),
        .req_address       (req_address),
        .req_burstcount    (req_burstcount),
        .req_writedata     (req_writedata),
        .req_byteenable    (req_byteenable),
        .req_waitrequest   (req_waitrequest),
        .req_readdata      (req_readdata),
        .req_readdatavalid (req_readdatavalid),
        .m_read            (m_read),
        .m_write           (m_write),
        .m_address         (m_address),
        .m_burstcount      (m_burstcount),
        .m_writedata       (m_writedata),
        .m_byteenable      (m_byteenable),
        .m_waitrequest     (m_waitrequest),
        .m_readdata        (m_readdata),
        .m_readdatavalid   (m_readdatavalid)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int wr_seen = 0;

    // Requester side: 0 idle, 1 read pending, 2 write burst in progress.
    int             op_kind [N];
    logic [AW-1:0]  op_addr [N];
    int             op_bc   [N];
    int             op_left [N];
    logic [DW-1:0]  op_wdata[N];
    logic [BEW-1:0] op_be   [N];

    bit             bank_wait;
    bit             bank_rdv;
    logic [DW-1:0]  bank_data;

    // Reference model state.
    typedef struct {
        int id;
        int len;
    } rd_t;
    rd_t            trk_q[$];
    int             head_done;
    int             rr;
    bit             locked;
    int             owner;
    int             lock_left;
    int             lock_bc;
    logic [AW-1:0]  lock_addr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic arm_read(input int i, input int addr, input int bc);
        op_kind[i] = 1;
        op_addr[i] = AW'(addr);
        op_bc[i]   = bc;
    endtask

    task automatic arm_write(input int i, input int addr, input int bc);
        op_kind[i]  = 2;
        op_addr[i]  = AW'(addr);
        op_bc[i]    = bc;
        op_left[i]  = bc;
        op_wdata[i] = {$urandom, $urandom};
        op_be[i]    = BEW'($urandom);
    endtask

    task automatic model_reset();
        trk_q.delete();
        head_done = 0;
        rr        = 0;
        locked    = 0;
        owner     = 0;
        lock_left = 0;
        for (int i = 0; i < N; i++) op_kind[i] = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_read[i]                    = (op_kind[i] == 1);
            req_write[i]                   = (op_kind[i] == 2);
            req_address[i*AW +: AW]        = op_addr[i];
            req_burstcount[i*BW +: BW]     = BW'(op_bc[i]);
            req_writedata[i*DW +: DW]      = op_wdata[i];
            req_byteenable[i*BEW +: BEW]   = op_be[i];
        end
        m_waitrequest   = bank_wait;
        m_readdatavalid = bank_rdv && (trk_q.size() > 0);
        bank_data       = {$urandom, $urandom};
        m_readdata      = bank_data;
    endtask

    // One clock: drive at the falling edge, check settled outputs, advance the model.
    task automatic step();
        int           g;
        bit           full;
        bit           exp_rd;
        bit           exp_wr;
        bit           exp_wait;
        logic [N-1:0] exp_rdv;
        rd_t          e;
        drive();
        #1;
        g = -1;
        if (locked) g = owner;
        else begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (rr + k) % N;
                if (g < 0 && op_kind[idx] != 0) g = idx;
            end
        end
        full   = (trk_q.size() == DEPTH);
        exp_rd = 0;
        exp_wr = 0;
        if (g >= 0) begin
            exp_rd = !locked && op_kind[g] == 1 && !full;
            exp_wr = op_kind[g] == 2;
        end
        chk("m_read", m_read, exp_rd);
        chk("m_write", m_write, exp_wr);
        if (exp_rd || exp_wr) begin
            chk("m_address", m_address, locked ? lock_addr : op_addr[g]);
            chk("m_burstcount", m_burstcount, locked ? lock_bc : op_bc[g]);
        end
        if (exp_wr) begin
            chk("m_writedata", m_writedata, op_wdata[g]);
            chk("m_byteenable", m_byteenable, op_be[g]);
        end
        for (int i = 0; i < N; i++) begin
            if (op_kind[i] != 0) begin
                exp_wait = !(i == g && !bank_wait && (op_kind[i] == 2 || (!locked && !full)));
                chk($sformatf("waitreq%0d", i), req_waitrequest[i], exp_wait);
            end
        end
        exp_rdv = '0;
        if (m_readdatavalid) exp_rdv[trk_q[0].id] = 1'b1;
        chk("readdatavalid", req_readdatavalid, exp_rdv);
        if (m_readdatavalid) chk("readdata", req_readdata, bank_data);
        if (m_write && !m_waitrequest) wr_seen++;

        if (m_readdatavalid) begin
            head_done++;
            if (head_done == trk_q[0].len) begin
                void'(trk_q.pop_front());
                head_done = 0;
            end
        end
        if ((exp_rd || exp_wr) && !bank_wait) begin
            rr = (g + 1) % N;
            if (exp_rd) begin
                e.id  = g;
                e.len = op_bc[g];
                trk_q.push_back(e);
                op_kind[g] = 0;
            end else begin
                if (locked) begin
                    lock_left--;
                    if (lock_left == 0) locked = 0;
                end else if (op_bc[g] > 1) begin
                    locked    = 1;
                    owner     = g;
                    lock_left = op_bc[g] - 1;
                    lock_addr = op_addr[g];
                    lock_bc   = op_bc[g];
                end
                op_left[g]--;
                if (op_left[g] == 0) op_kind[g] = 0;
                else begin
                    op_wdata[g] = {$urandom, $urandom};
                    op_be[g]    = BEW'($urandom);
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < N; i++) begin
            op_addr[i]  = '0;
            op_bc[i]    = 1;
            op_left[i]  = 0;
            op_wdata[i] = '0;
            op_be[i]    = '0;
        end
        bank_wait = 0;
        bank_rdv  = 0;

        // Reset values, with a requester already asking.
        arm_read(0, 'h10, 4);
        drive();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_waitreq", req_waitrequest, {N{1'b1}});
        chk("rst_m_read", m_read, 1'b0);
        chk("rst_m_write", m_write, 1'b0);
        chk("rst_rdv", req_readdatavalid, '0);
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Single read, burst 4, routed back to requester 0.
        arm_read(0, 'h10, 4);
        step();
        bank_rdv = 1;
        repeat (4) step();

        // Two requesters reading back to back: alternating grants, in-order data.
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < N; i++)
                if (op_kind[i] == 0) arm_read(i, 'h100 * (i + 1) + c, 1 + (c % 3));
            bank_rdv = (c > 1);
            step();
        end
        for (int i = 0; i < N; i++) op_kind[i] = 0;
        bank_rdv = 1;
        repeat (30) step();

        // Write burst of 8 holds the grant against a later read.
        arm_write(0, 'h200, 8);
        step();
        arm_read(1, 'h280, 2);
        repeat (8) step();
        repeat (6) step();

        // Bank stall in the middle of a write burst.
        wr_seen = 0;
        arm_write(1, 'h300, 8);
        repeat (3) step();
        bank_wait = 1;
        repeat (5) step();
        bank_wait = 0;
        repeat (6) step();
        chk("burst_beats", wr_seen, 8);

        // Fill the tracker, then a read stalls while a write still goes through.
        bank_rdv = 0;
        for (int k = 0; k < DEPTH; k++) begin
            arm_read(0, k, 1);
            step();
        end
        arm_read(0, 'h3ff, 1);
        arm_write(1, 'h400, 1);
        wr_seen = 0;
        step();
        chk("full_write_accepted", wr_seen, 1);
        step();
        bank_rdv = 1;
        step();
        step();
        repeat (70) step();

        // Reset in the middle of a read burst, then a fresh read.
        arm_read(0, 'h40, 4);
        bank_rdv = 0;
        step();
        bank_rdv = 1;
        repeat (2) step();
        arm_read(1, 'h44, 1);
        drive();
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_waitreq", req_waitrequest, {N{1'b1}});
        chk("midrst_m_read", m_read, 1'b0);
        chk("midrst_rdv", req_readdatavalid, '0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        arm_read(1, 'h50, 2);
        bank_rdv = 0;
        step();
        bank_rdv = 1;
        repeat (3) step();

        // Randomized traffic.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if (op_kind[i] == 0 && $urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 1) == 1)
                        arm_read(i, int'($urandom), int'($urandom_range(1, 4)));
                    else
                        arm_write(i, int'($urandom), int'($urandom_range(1, 8)));
                end
            end
            bank_wait = ($urandom_range(0, 3) == 0);
            bank_rdv  = ($urandom_range(0, 1) == 1);
            step();
        end
        bank_wait = 0;
        bank_rdv  = 1;
        repeat (400) step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
